// File: rtl/conv_layer_sequencer.sv
// Tiles a conv layer across the systolic array: per tile clears weight fill, loads, feeds, drains.
// Outputs are registered from next state; start is sampled only in IDLE and done levels only in their waiting state.
module conv_layer_sequencer #(
    parameter int array_size    = 9,
    parameter int dim_data_size = 16,
    parameter int addr_width    = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_width-1:0]    weight_base,
    input  logic [dim_data_size-1:0] weight_size,
    input  logic [dim_data_size-1:0] number_filters,
    input  logic                     wf_done,
    input  logic                     feed_done,
    input  logic                     drain_done,
    output logic                     wf_reset_n,
    output logic                     wf_enable,
    output logic [addr_width-1:0]    wf_initial_address,
    output logic [dim_data_size-1:0] wf_number_filters,
    output logic                     feed_start,
    output logic                     drain_start,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [dim_data_size-1:0] tile_index
);
    localparam int W = 2*dim_data_size + 8;

    typedef enum logic [2:0] {IDLE, CHECK, CLR, LOAD, FEED, DRAIN, NEXT, FIN} state_t;
    state_t state, state_next;

    logic [addr_width-1:0]    base_q;
    logic [dim_data_size-1:0] k_q;
    logic [dim_data_size-1:0] f_q;
    logic                     load_first;

    logic [W-1:0] k_sq, f_w, asz_w, tile_w, tile_calc, offs, remain, nf_w;
    logic         bad, last_tile;
    logic [addr_width-1:0]    addr_calc;
    logic [dim_data_size-1:0] nf_calc;

    // Tile geometry; in NEXT it is evaluated for the tile about to start.
    always_comb begin
        k_sq      = W'(k_q) * W'(k_q);
        f_w       = W'(f_q);
        asz_w     = W'(array_size);
        tile_w    = W'(tile_index);
        tile_calc = (state == NEXT) ? tile_w + W'(1) : tile_w;
        offs      = tile_calc * asz_w * k_sq;
        remain    = f_w - tile_calc * asz_w;
        nf_w      = (remain < asz_w) ? remain : asz_w;
        addr_calc = addr_width'(W'(base_q) + offs);
        nf_calc   = dim_data_size'(nf_w);
        bad       = (k_q == '0) || (f_q == '0) || (k_sq > asz_w);
        last_tile = ((tile_w + W'(1)) * asz_w) >= f_w;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CHECK;
            CHECK:   state_next = bad ? IDLE : CLR;
            CLR:     state_next = LOAD;
            LOAD:    if (!load_first && wf_done) state_next = FEED;
            FEED:    if (feed_done) state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = NEXT;
            NEXT:    state_next = last_tile ? FIN : CLR;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            base_q             <= '0;
            k_q                <= '0;
            f_q                <= '0;
            load_first         <= 1'b0;
            tile_index         <= '0;
            wf_reset_n         <= 1'b0;
            wf_enable          <= 1'b0;
            wf_initial_address <= '0;
            wf_number_filters  <= '0;
            feed_start         <= 1'b0;
            drain_start        <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
        end else begin
            state       <= state_next;
            wf_reset_n  <= (state_next != CLR);
            wf_enable   <= (state_next == LOAD) || (state_next == FEED) ||
                           (state_next == DRAIN) || (state_next == NEXT);
            feed_start  <= (state == LOAD) && (state_next == FEED);
            drain_start <= (state == FEED) && (state_next == DRAIN);
            load_first  <= (state != LOAD) && (state_next == LOAD);
            busy        <= (state_next != IDLE);
            done        <= (state_next == FIN);
            error       <= (state == CHECK) && bad;
            if (state == IDLE && start) begin
                base_q     <= weight_base;
                k_q        <= weight_size;
                f_q        <= number_filters;
                tile_index <= '0;
            end
            if ((state == CHECK && !bad) || (state == NEXT && !last_tile)) begin
                wf_initial_address <= addr_calc;
                wf_number_filters  <= nf_calc;
            end
            if (state == NEXT && !last_tile)
                tile_index <= tile_index + 1'b1;
        end
    end
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer: single/multi tile layers, config errors, mid-layer reset, stray start.
module tb_conv_layer_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [14:0] weight_base;
    logic [15:0] weight_size;
    logic [15:0] number_filters;
    logic        wf_done, feed_done, drain_done;
    logic        wf_reset_n, wf_enable;
    logic [14:0] wf_initial_address;
    logic [15:0] wf_number_filters;
    logic        feed_start, drain_start, busy, done, error;
    logic [15:0] tile_index;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_layer_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .weight_base(weight_base), .weight_size(weight_size), .number_filters(number_filters),
        .wf_done(wf_done), .feed_done(feed_done), .drain_done(drain_done),
        .wf_reset_n(wf_reset_n), .wf_enable(wf_enable),
        .wf_initial_address(wf_initial_address), .wf_number_filters(wf_number_filters),
        .feed_start(feed_start), .drain_start(drain_start),
        .busy(busy), .done(done), .error(error), .tile_index(tile_index)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_en"}, wf_enable, 0);
        chk({tag, "_addr"}, wf_initial_address, 0);
        chk({tag, "_nf"}, wf_number_filters, 0);
        chk({tag, "_tile"}, tile_index, 0);
        chk({tag, "_fs"}, feed_start, 0);
        chk({tag, "_ds"}, drain_start, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, error, 0);
    endtask

    // Entered while the DUT sits in CLR; returns one cycle after NEXT.
    task automatic run_tile(input logic [14:0] ea, input logic [15:0] en, input logic [15:0] et,
                            input logic poke_start);
        chk("clr_rstn", wf_reset_n, 0);
        chk("clr_en", wf_enable, 0);
        chk("clr_addr", wf_initial_address, ea);
        chk("clr_nf", wf_number_filters, en);
        chk("clr_tile", tile_index, et);
        tick();
        chk("load_en", wf_enable, 1);
        chk("load_rstn", wf_reset_n, 1);
        wf_done = 1'b1;
        drain_done = 1'b1;
        if (poke_start) begin
            start = 1'b1;
            weight_base = 15'd999;
            weight_size = 16'd4;
        end
        tick();
        start = 1'b0;
        chk("load2_fs", feed_start, 0);
        chk("load2_en", wf_enable, 1);
        tick();
        chk("feed_start", feed_start, 1);
        chk("feed_en", wf_enable, 1);
        wf_done = 1'b0;
        feed_done = 1'b1;
        tick();
        chk("drain_start", drain_start, 1);
        chk("drain_fs", feed_start, 0);
        feed_done = 1'b0;
        tick();
        chk("next_busy", busy, 1);
        chk("next_ds", drain_start, 0);
        chk("next_done", done, 0);
        drain_done = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        weight_base = '0;
        weight_size = '0;
        number_filters = '0;
        wf_done = 1'b0;
        feed_done = 1'b0;
        drain_done = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk_idle_zero("rst");
        chk("rst_rstn", wf_reset_n, 0);
        tick();
        chk("rst_hold_rstn", wf_reset_n, 0);
        reset = 1'b1;
        tick();
        chk("rel_rstn", wf_reset_n, 1);
        chk("rel_busy", busy, 0);

        // Single tile: K=3, F=4, base=100; inputs changed after start must be ignored
        weight_base = 15'd100; weight_size = 16'd3; number_filters = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        weight_base = 15'd7; number_filters = 16'd1;
        chk("t1_check_busy", busy, 1);
        chk("t1_check_err", error, 0);
        tick();
        run_tile(15'd100, 16'd4, 16'd0, 1'b0);
        chk("t1_fin_done", done, 1);
        chk("t1_fin_en", wf_enable, 0);
        chk("t1_fin_tile", tile_index, 0);
        tick();
        chk("t1_idle_done", done, 0);
        chk("t1_idle_busy", busy, 0);

        // Three tiles: K=3, F=20, base=0
        weight_base = 15'd0; weight_size = 16'd3; number_filters = 16'd20; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        run_tile(15'd0, 16'd9, 16'd0, 1'b0);
        run_tile(15'd81, 16'd9, 16'd1, 1'b0);
        run_tile(15'd162, 16'd2, 16'd2, 1'b0);
        chk("t2_fin_done", done, 1);
        tick();
        chk("t2_idle_done", done, 0);
        chk("t2_idle_busy", busy, 0);

        // K=4: 16 > 9
        weight_size = 16'd4; number_filters = 16'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("e1_check_busy", busy, 1);
        chk("e1_check_err", error, 0);
        tick();
        chk("e1_err", error, 1);
        chk("e1_busy", busy, 0);
        chk("e1_en", wf_enable, 0);
        chk("e1_rstn", wf_reset_n, 1);
        tick();
        chk("e1_err_off", error, 0);

        // F=0
        weight_size = 16'd3; number_filters = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("e2_err", error, 1);
        chk("e2_busy", busy, 0);
        chk("e2_en", wf_enable, 0);
        tick();
        chk("e2_err_off", error, 0);

        // Reset during FEED of tile 1, then a fresh layer
        weight_base = 15'd0; weight_size = 16'd3; number_filters = 16'd20; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        run_tile(15'd0, 16'd9, 16'd0, 1'b0);
        tick();
        wf_done = 1'b1;
        tick();
        tick();
        chk("r_feed_fs", feed_start, 1);
        chk("r_feed_tile", tile_index, 1);
        wf_done = 1'b0;
        reset = 1'b0;
        #1;
        chk_idle_zero("r_async");
        chk("r_async_rstn", wf_reset_n, 0);
        feed_done = 1'b1;
        drain_done = 1'b1;
        tick();
        chk("r_hold_done", done, 0);
        chk("r_hold_busy", busy, 0);
        feed_done = 1'b0;
        drain_done = 1'b0;
        reset = 1'b1;
        tick();
        chk("r_rel_rstn", wf_reset_n, 1);
        chk("r_rel_done", done, 0);
        chk("r_rel_err", error, 0);
        weight_base = 15'd50; weight_size = 16'd3; number_filters = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        run_tile(15'd50, 16'd4, 16'd0, 1'b0);
        chk("r_fin_done", done, 1);
        tick();

        // K=2, F=10, base=5; wf_done held through CLR, start pulsed in LOAD
        weight_base = 15'd5; weight_size = 16'd2; number_filters = 16'd10; start = 1'b1;
        tick();
        start = 1'b0;
        wf_done = 1'b1;
        tick();
        run_tile(15'd5, 16'd9, 16'd0, 1'b1);
        wf_done = 1'b1;
        run_tile(15'd41, 16'd1, 16'd1, 1'b0);
        chk("s_fin_done", done, 1);
        tick();
        chk("s_idle_busy", busy, 0);
        chk("s_idle_done", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_layer_sequencer.md
CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 SHALL have parameter array_size, default 9, systolic array dimension (max filters per tile).
REQ-002 SHALL have parameter dim_data_size, default 16, width of dimension/count fields.
REQ-003 SHALL have parameter addr_width, default 15, weight ROM address width.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  begin layer; sampled in IDLE only.
REQ-007 SHALL have port weight_base  input  addr_width  ROM address of filter 0, element 0.
REQ-008 SHALL have port weight_size  input  dim_data_size  kernel side K.
REQ-009 SHALL have port number_filters  input  dim_data_size  total filters F.
REQ-010 SHALL have ports wf_done, feed_done, drain_done  input  1 each  completion levels from weight fill, input feeder, output drain.
REQ-011 SHALL have port wf_reset_n  output  1  active-low restart to weight fill block.
REQ-012 SHALL have port wf_enable  output  1  weight fill enable.
REQ-013 SHALL have port wf_initial_address  output  addr_width  tile base address.
REQ-014 SHALL have port wf_number_filters  output  dim_data_size  filters in current tile.
REQ-015 SHALL have ports feed_start, drain_start  output  1 each  one-cycle start pulses.
REQ-016 SHALL have ports busy, done, error  output  1 each  status; done and error are one-cycle pulses.
REQ-017 SHALL have port tile_index  output  dim_data_size  current tile number, 0-based.

Function
REQ-018 SHALL implement states IDLE, CHECK, CLR, LOAD, FEED, DRAIN, NEXT, FIN.
REQ-019 IDLE: start=1 -> latch weight_base, K, F into internal registers, tile_index=0, go CHECK; later input changes ignored until FIN.
REQ-020 CHECK: K==0, F==0, or K*K > array_size -> error pulse 1 cycle, go IDLE; else go CLR.
REQ-021 CHECK/NEXT SHALL compute wf_number_filters = min(array_size, F - tile_index*array_size) and wf_initial_address = weight_base + tile_index*array_size*K*K, truncated to addr_width.
REQ-022 CLR: wf_reset_n=0 for exactly one cycle, wf_enable=0; go LOAD.
REQ-023 LOAD: wf_enable=1 held; wf_done=1 sampled -> go FEED; wf_done ignored in its first LOAD cycle.
REQ-024 FEED: feed_start=1 on first FEED cycle only; feed_done=1 -> go DRAIN; wf_enable remains 1 (weights held).
REQ-025 DRAIN: drain_start=1 on first DRAIN cycle only; drain_done=1 -> go NEXT.
REQ-026 NEXT: (tile_index+1)*array_size >= F -> go FIN; else tile_index+1, recompute REQ-021, go CLR.
REQ-027 FIN: done=1 one cycle, wf_enable=0, go IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 start asserted while busy SHALL be ignored; no queueing.
REQ-030 Done signal and start arriving in same cycle outside their waiting state SHALL be ignored.
REQ-031 Arithmetic SHALL use at least 2*dim_data_size bits internally before truncation.

Reset
REQ-032 reset=0 SHALL asynchronously force IDLE, tile_index=0, wf_reset_n=0, wf_enable=0, wf_initial_address=0, wf_number_filters=0, feed_start=0, drain_start=0, busy=0, done=0, error=0.
REQ-033 wf_reset_n SHALL return to 1 on the first clock edge after reset deasserts (in IDLE).
REQ-034 reset mid-operation SHALL abandon the layer; no done or error pulse follows.

Verification
REQ-035 K=3, F=4, base=100, start -> CLR pulse, wf_number_filters=4, wf_initial_address=100, one feed_start, one drain_start, done pulse, tile_index=0.
REQ-036 K=3, F=20, base=0, array_size=9 -> 3 tiles: addresses 0, 81, 162; filter counts 9, 9, 2; three CLR pulses; single done.
REQ-037 K=4 (16>9) or F=0 -> error pulse one cycle after CHECK entry, no wf_enable, busy back to 0.
REQ-038 reset low during FEED of tile 1 -> all outputs at reset values immediately; no done; new start runs from tile 0.
REQ-039 start pulsed during LOAD and wf_done held high across CLR -> no restart; LOAD still lasts at least 2 cycles.
